// File: rtl/function_engine_pkg.sv
// function_engine_pkg: shared enums for the function engine.
//   mode_t  - request kind: factorial, quadratic, inverse quadratic, reserved
//   state_t - handshake FSM states
package function_engine_pkg;
    typedef enum logic [1:0] {FACT, QUAD, INVQ, RSVD} mode_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/func_quadratic.sv
// func_quadratic: combinational y = A*x^2 + B*x + C, 32-bit signed, truncated to W_Y.
//   x - signed argument (W_X bits)
//   y - signed value (W_Y bits)
module func_quadratic #(
    parameter int W_X = 4,
    parameter int W_Y = 8,
    parameter int A = 1,
    parameter int B = 10,
    parameter int C = -10
) (
    input  logic signed [W_X-1:0] x,
    output logic signed [W_Y-1:0] y
);
    logic signed [31:0] xe;
    assign xe = 32'(x);
    assign y = W_Y'(A * xe * xe + B * xe + C);
endmodule

// File: rtl/function_engine.sv
// function_engine: handshaked factorial / quadratic / inverse-quadratic engine.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - request handshake; mode and operand latched on accept
//   mode, operand       - request kind and argument (low W_X bits) or target y
//   out_valid, out_ready- result handshake; result and err held until taken
//   result, err         - signed result; err flags the reserved mode
module function_engine
    import function_engine_pkg::*;
#(
    parameter int W_X = 4,
    parameter int W_Y = 8,
    parameter int A = 1,
    parameter int B = 10,
    parameter int C = -10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic [W_Y-1:0] operand,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_Y-1:0] result,
    output logic           err
);
    state_t               state;
    mode_t                md;
    logic [W_Y-1:0]       op;
    logic [W_Y-1:0]       acc;
    // factorial countdown, or sweep index ux for the inverse search
    logic [W_X-1:0]       cnt;
    logic [W_Y+1:0]       min_err;
    logic signed [W_X-1:0] qx;
    logic signed [W_Y-1:0] qy;
    logic [W_Y+1:0]       diff;
    logic [W_Y+1:0]       err_abs;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign qx = (md == INVQ) ? cnt : op[W_X-1:0];

    func_quadratic #(.W_X(W_X), .W_Y(W_Y), .A(A), .B(B), .C(C)) u_quad (
        .x(qx),
        .y(qy)
    );

    // two guard bits so |y - quad(x)| never wraps
    assign diff    = {{2{op[W_Y-1]}}, op} - {{2{qy[W_Y-1]}}, qy};
    assign err_abs = diff[W_Y+1] ? -diff : diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            md      <= FACT;
            op      <= '0;
            acc     <= '0;
            cnt     <= '0;
            min_err <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    md      <= mode_t'(mode);
                    op      <= operand;
                    acc     <= W_Y'(1);
                    cnt     <= (mode_t'(mode) == INVQ) ? '0 : operand[W_X-1:0];
                    min_err <= (W_Y+2)'(1) << W_Y;
                    result  <= '0;
                    err     <= 1'b0;
                    state   <= CALC;
                end
                CALC: case (md)
                    FACT: if (cnt == '0) begin
                        result <= acc;
                        state  <= DONE;
                    end else begin
                        acc <= acc * W_Y'(cnt);
                        cnt <= cnt - 1'b1;
                    end
                    QUAD: begin
                        result <= qy;
                        state  <= DONE;
                    end
                    INVQ: begin
                        // strict compare keeps the first minimum in sweep order
                        if (err_abs < min_err) begin
                            min_err <= err_abs;
                            result  <= {{(W_Y-W_X){qx[W_X-1]}}, qx};
                        end
                        cnt <= cnt + 1'b1;
                        if (&cnt) state <= DONE;
                    end
                    RSVD: begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= DONE;
                    end
                endcase
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_function_engine.sv
// tb_function_engine: table-driven check of function_engine plus handshake/reset sequences.
module tb_function_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] mode = 2'd0;
    logic [7:0] operand = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function_engine #(.W_X(4), .W_Y(8), .A(1), .B(10), .C(-10)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .operand(operand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .err(err)
    );

    typedef struct {
        logic [1:0] m;
        logic [7:0] op;
        logic [7:0] res;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic run(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        chk({name, " ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        mode = v.m;
        operand = v.op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        operand = 8'($urandom);
        mode = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " lat"}, lat, v.lat);
        chk({name, " res"}, int'(result), int'(v.res));
        chk({name, " err"}, int'(err), int'(v.e));
        chk({name, " busy"}, int'(in_ready), 0);
    endtask

    initial begin
        vt[0]  = '{2'd0, 8'd5,    8'd120,  1'b0, 7};
        vt[1]  = '{2'd0, 8'd6,    8'hD0,   1'b0, 8};
        vt[2]  = '{2'd0, 8'd0,    8'd1,    1'b0, 2};
        vt[3]  = '{2'd0, 8'd1,    8'd1,    1'b0, 3};
        vt[4]  = '{2'd0, 8'd3,    8'd6,    1'b0, 5};
        vt[5]  = '{2'd0, 8'h25,   8'd120,  1'b0, 7};
        vt[6]  = '{2'd1, 8'd2,    8'd14,   1'b0, 2};
        vt[7]  = '{2'd1, 8'h0D,   8'hE1,   1'b0, 2};
        vt[8]  = '{2'd1, 8'd7,    8'd109,  1'b0, 2};
        vt[9]  = '{2'd1, 8'h08,   8'hE6,   1'b0, 2};
        vt[10] = '{2'd1, 8'hF2,   8'd14,   1'b0, 2};
        vt[11] = '{2'd2, 8'd14,   8'd2,    1'b0, 17};
        vt[12] = '{2'd2, 8'hDD,   8'hFB,   1'b0, 17};
        vt[13] = '{2'd2, 8'hDE,   8'hFA,   1'b0, 17};
        vt[14] = '{2'd2, 8'hE6,   8'hF8,   1'b0, 17};
        vt[15] = '{2'd2, 8'd127,  8'd7,    1'b0, 17};
        vt[16] = '{2'd2, 8'd0,    8'd1,    1'b0, 17};
        vt[17] = '{2'd3, 8'h55,   8'd0,    1'b1, 2};
        vt[18] = '{2'd1, 8'd3,    8'd29,   1'b0, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset err", int'(err), 0);

        for (int i = 0; i < 19; i++) run($sformatf("vec%0d", i), vt[i]);

        // backpressure: result holds, second request waits for handoff
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        mode = 2'd1;
        operand = 8'd2;
        @(negedge clk);
        mode = 2'd1;
        operand = 8'd3;
        @(negedge clk);
        chk("bp first valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold valid", int'(out_valid), 1);
            chk("bp hold res", int'(result), 14);
            chk("bp hold ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp handoff valid", int'(out_valid), 0);
        chk("bp handoff ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second calc", int'(in_ready), 0);
        @(negedge clk);
        chk("bp second valid", int'(out_valid), 1);
        chk("bp second res", int'(result), 29);

        // reset in the middle of a sweep abandons it
        @(negedge clk);
        in_valid = 1'b1;
        mode = 2'd2;
        operand = 8'd14;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid ready", int'(in_ready), 1);
        chk("rst mid result", int'(result), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (out_valid) seen++;
                @(negedge clk);
            end
            chk("rst no valid", seen, 0);
        end
        run("post rst", vt[6]);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
